// File: rtl/pour_move_sequencer.sv
// pour_move_sequencer - buffers legal (src,dst) pour moves and replays them one per cycle on start
module pour_move_sequencer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_src,
    input  logic [1:0]               in_dst,
    input  logic                     start,
    output logic [1:0]               src,
    output logic [1:0]               dst,
    output logic                     move_valid,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         move_cnt,
    output logic [CNT_W-1:0]         reject_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_next;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          legal, accept, push, pop, clr_cnt;

    assign in_ready = (level != LW'(DEPTH));
    // Index 3 is not a bucket; a pour onto itself is meaningless.
    assign legal    = (in_src != 2'd3) && (in_dst != 2'd3) && (in_src != in_dst);
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign pop      = (state == RUN) && (level != '0);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_comb begin
        state_next = state;
        clr_cnt    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    clr_cnt    = 1'b1;
                    state_next = (level != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // Leave only when this pop empties the FIFO and nothing refills it.
                if ((level == '0) || (pop && (level == LW'(1)) && !push))
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_src, in_dst};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            src        <= 2'd0;
            dst        <= 2'd1;
            move_valid <= 1'b0;
            move_cnt   <= '0;
            reject_cnt <= '0;
        end else begin
            state      <= state_next;
            move_valid <= pop;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                {src, dst} <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (clr_cnt)
                move_cnt <= '0;
            else if (pop && (move_cnt != CNT_MAX))
                move_cnt <= move_cnt + 1'b1;
            if (accept && !legal && (reject_cnt != CNT_MAX))
                reject_cnt <= reject_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pour_move_sequencer.sv
// tb/tb_pour_move_sequencer.sv - randomized and directed checks of pour_move_sequencer against a queue model
module tb_pour_move_sequencer;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       start = 1'b0;
    logic [1:0] in_src = 2'd0;
    logic [1:0] in_dst = 2'd0;
    logic       in_ready, move_valid, busy, done;
    logic [1:0] src, dst;
    logic [3:0] level;
    logic [CNT_W-1:0] move_cnt, reject_cnt;

    pour_move_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_src(in_src), .in_dst(in_dst), .start(start), .src(src), .dst(dst),
        .move_valid(move_valid), .busy(busy), .done(done), .level(level),
        .move_cnt(move_cnt), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] q[$];
    bit         m_run, m_done, m_mv;
    logic [1:0] m_src, m_dst;
    int         m_cnt, m_rej;

    wire [19:0] obs = {in_ready, level, move_valid, src, dst, busy, done, move_cnt, reject_cnt};

    function automatic logic [19:0] expv();
        return {q.size() != DEPTH, 4'(q.size()), m_mv, m_src, m_dst, m_run, m_done,
                CNT_W'(m_cnt), CNT_W'(m_rej)};
    endfunction

    task automatic model_reset();
        q.delete();
        m_run = 0; m_done = 0; m_mv = 0;
        m_src = 2'd0; m_dst = 2'd1;
        m_cnt = 0; m_rej = 0;
    endtask

    // One clock: drive inputs, advance the queue model by the pour-sequencer rules.
    task automatic step(input bit v, input logic [1:0] s, input logic [1:0] d, input bit st,
                        output bit acc);
        int  n;
        bit  pop, legal;
        logic [3:0] e;
        in_valid = v; in_src = s; in_dst = d; start = st;
        acc = v && (q.size() != DEPTH);
        legal = (s <= 2) && (d <= 2) && (s != d);
        @(posedge clk); #1;
        n = q.size();
        pop = m_run && (n != 0);
        m_mv = pop;
        if (pop) begin
            e = q.pop_front();
            m_src = e[3:2]; m_dst = e[1:0];
            if (m_cnt < CMAX) m_cnt++;
        end
        if (acc) begin
            if (legal) q.push_back({s, d});
            else if (m_rej < CMAX) m_rej++;
        end
        if (m_run) begin
            if (q.size() == 0) begin m_run = 0; m_done = 1; end
        end else if (st) begin
            m_cnt = 0; m_done = 0;
            if (n != 0) m_run = 1; else m_done = 1;
        end
        in_valid = 0; start = 0;
    endtask

    task automatic test_reset();
        bit acc;
        rst_n = 0; model_reset();
        @(posedge clk); #1;
        vectors++;
        if (obs !== expv()) begin miscompares++; $display("FAIL reset_state obs=%h exp=%h", obs, expv()); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        rst_n = 1;
        step(0, 0, 0, 0, acc);
        vectors++;
        if (obs !== expv()) begin miscompares++; $display("FAIL reset_idle obs=%h exp=%h", obs, expv()); end
    endtask

    task automatic test_solution();
        logic [1:0] ms [7] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2};
        logic [1:0] md [7] = '{2'd1, 2'd2, 2'd0, 2'd2, 2'd1, 2'd2, 2'd0};
        int cap [3] = '{8, 5, 3};
        int b [3] = '{8, 0, 0};
        int nmv = 0, amt;
        bit acc;
        for (int i = 0; i < 7; i++) begin
            step(1, ms[i], md[i], 0, acc);
            vectors++;
            if (obs !== expv()) begin miscompares++; $display("FAIL solution_push obs=%h exp=%h", obs, expv()); end
        end
        step(0, 0, 0, 1, acc);
        for (int c = 0; c < 20 && !done; c++) begin
            step(0, 0, 0, 0, acc);
            vectors++;
            if (obs !== expv()) begin miscompares++; $display("FAIL solution_run obs=%h exp=%h", obs, expv()); end
            if (move_valid) begin
                amt = (b[src] < cap[dst] - b[dst]) ? b[src] : cap[dst] - b[dst];
                b[src] -= amt; b[dst] += amt;
                nmv++;
            end
        end
        vectors++;
        if (!(done === 1'b1 && move_cnt === 4'd7 && nmv == 7))
        begin miscompares++; $display("FAIL solution_done done=%b cnt=%0d moves=%0d want 1/7/7", done, move_cnt, nmv); end
        vectors++;
        if (b[0] != 4 || b[1] != 4 || b[2] != 0)
        begin miscompares++; $display("FAIL solution_buckets got=%0d,%0d,%0d want=4,4,0", b[0], b[1], b[2]); end
    endtask

    task automatic test_illegal();
        logic [1:0] ms [3] = '{2'd0, 2'd3, 2'd1};
        logic [1:0] md [3] = '{2'd0, 2'd1, 2'd3};
        int r0 = reject_cnt;
        bit acc;
        for (int i = 0; i < 3; i++) begin
            step(1, ms[i], md[i], 0, acc);
            vectors++;
            if (!acc) begin miscompares++; $display("FAIL illegal_accept idx=%0d got=0 want=1", i); end
        end
        vectors++;
        if (level !== 4'd0 || int'(reject_cnt) != r0 + 3)
        begin miscompares++; $display("FAIL illegal_count level=%0d rej=%0d want 0/%0d", level, reject_cnt, r0 + 3); end
        step(0, 0, 0, 1, acc);
        vectors++;
        if (done !== 1'b1 || move_valid !== 1'b0 || obs !== expv())
        begin miscompares++; $display("FAIL illegal_start done=%b mv=%b want 1/0", done, move_valid); end
    endtask

    task automatic test_full();
        bit acc, seen_block = 0;
        int pushed = 0;
        for (int c = 0; c < 40 && pushed < DEPTH + 1; c++) begin
            step(1, 2'd0, 2'd2, (c == DEPTH + 2), acc);
            if (acc) pushed++;
            vectors++;
            if (obs !== expv()) begin miscompares++; $display("FAIL full_cycle obs=%h exp=%h", obs, expv()); end
            if (level == 4'(DEPTH) && in_ready === 1'b0) seen_block = 1;
        end
        vectors++;
        if (pushed != DEPTH + 1 || !seen_block)
        begin miscompares++; $display("FAIL full_block pushed=%0d blocked=%b want %0d/1", pushed, seen_block, DEPTH + 1); end
        for (int c = 0; c < 30 && !done; c++) begin
            step(0, 0, 0, 0, acc);
            vectors++;
            if (obs !== expv()) begin miscompares++; $display("FAIL full_drain obs=%h exp=%h", obs, expv()); end
        end
        vectors++;
        if (done !== 1'b1 || move_cnt !== 4'(DEPTH + 1))
        begin miscompares++; $display("FAIL full_done done=%b cnt=%0d want 1/%0d", done, move_cnt, DEPTH + 1); end
    endtask

    task automatic test_run_push();
        bit acc;
        int maxl = 0, nmv = 0, gaps = 0;
        bit started = 0;
        step(1, 2'd1, 2'd0, 0, acc);
        step(1, 2'd2, 2'd1, 0, acc);
        step(0, 0, 0, 1, acc);
        for (int c = 0; c < 20 && !done; c++) begin
            step(c == 0, 2'd0, 2'd2, 0, acc);
            vectors++;
            if (obs !== expv()) begin miscompares++; $display("FAIL runpush_cycle obs=%h exp=%h", obs, expv()); end
            if (level > maxl) maxl = level;
            if (move_valid) begin nmv++; started = 1; end
            else if (started && !done) gaps++;
        end
        vectors++;
        if (nmv != 3 || gaps != 0 || move_cnt !== 4'd3 || maxl > 2)
        begin miscompares++; $display("FAIL runpush_result moves=%0d gaps=%0d cnt=%0d maxlvl=%0d want 3/0/3/<=2", nmv, gaps, move_cnt, maxl); end
    endtask

    task automatic test_reset_mid_run();
        bit acc;
        int nmv = 0;
        for (int i = 0; i < 7; i++) step(1, 2'(i % 3), 2'((i + 1) % 3), 0, acc);
        step(0, 0, 0, 1, acc);
        for (int c = 0; c < 20 && nmv < 3; c++) begin
            step(0, 0, 0, 0, acc);
            if (move_valid) nmv++;
        end
        vectors++;
        if (nmv != 3 || busy !== 1'b1) begin miscompares++; $display("FAIL midrun_reach moves=%0d busy=%b want 3/1", nmv, busy); end
        #2 rst_n = 0; model_reset();
        #1;
        vectors++;
        if (obs !== expv()) begin miscompares++; $display("FAIL midrun_async obs=%h exp=%h", obs, expv()); end
        @(posedge clk); #1 rst_n = 1;
        step(0, 0, 0, 1, acc);
        vectors++;
        if (done !== 1'b1 || move_valid !== 1'b0 || obs !== expv())
        begin miscompares++; $display("FAIL midrun_empty_start done=%b mv=%b want 1/0", done, move_valid); end
    endtask

    task automatic test_saturate();
        bit acc;
        rst_n = 0; model_reset();
        @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < 20; i++) step(1, 2'd3, 2'(i % 4), 0, acc);
        vectors++;
        if (reject_cnt !== 4'd15 || obs !== expv())
        begin miscompares++; $display("FAIL saturate rej=%0d want 15", reject_cnt); end
    endtask

    task automatic test_random();
        bit acc;
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0, acc);
            vectors++;
            if (obs !== expv()) begin miscompares++; $display("FAIL random_cycle c=%0d obs=%h exp=%h", c, obs, expv()); end
        end
    endtask

    initial begin
        test_reset();
        test_solution();
        test_illegal();
        test_full();
        test_run_push();
        test_reset_mid_run();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
